// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two ALU requesters and the shared-ALU arbiter.
// The slave modport is the arbiter side; master is the requester/monitor side.
interface alu_share_arbiter_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid_in;
    logic             req0_ready_out;
    logic [5:0]       req0_func_in;
    logic [WIDTH-1:0] req0_a_in;
    logic [WIDTH-1:0] req0_b_in;
    logic             req1_valid_in;
    logic             req1_ready_out;
    logic [5:0]       req1_func_in;
    logic [WIDTH-1:0] req1_a_in;
    logic [WIDTH-1:0] req1_b_in;
    logic             rsp0_valid_out;
    logic             rsp0_ready_in;
    logic             rsp1_valid_out;
    logic             rsp1_ready_in;
    logic [WIDTH-1:0] rsp_result_out;
    logic             rsp_branch_out;
    logic             rsp_jump_out;
    logic [CNT_W-1:0] conflict_cnt_out;

    modport slave (
        input  req0_valid_in, req0_func_in, req0_a_in, req0_b_in,
        input  req1_valid_in, req1_func_in, req1_a_in, req1_b_in,
        input  rsp0_ready_in, rsp1_ready_in,
        output req0_ready_out, req1_ready_out,
        output rsp0_valid_out, rsp1_valid_out,
        output rsp_result_out, rsp_branch_out, rsp_jump_out, conflict_cnt_out
    );

    modport master (
        output req0_valid_in, req0_func_in, req0_a_in, req0_b_in,
        output req1_valid_in, req1_func_in, req1_a_in, req1_b_in,
        output rsp0_ready_in, rsp1_ready_in,
        input  req0_ready_out, req1_ready_out,
        input  rsp0_valid_out, rsp1_valid_out,
        input  rsp_result_out, rsp_branch_out, rsp_jump_out, conflict_cnt_out
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one Func-coded ALU between two requesters, with a
// one-entry registered response buffer and a saturating conflict counter.
module alu_share_arbiter #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    alu_share_arbiter_if.slave bus
);
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_BEQ  = 6'b001100;
    localparam logic [5:0] F_BNE  = 6'b001101;
    localparam logic [5:0] F_J    = 6'b001000;

    logic             full_q, full_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             branch_q, branch_d;
    logic             jump_q, jump_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             both_c, grant_vld_c, grant_c, drain_c, accept_c;
    logic [5:0]       func_c;
    logic [WIDTH-1:0] a_c, b_c, alu_o_c;
    logic             alu_br_c, alu_j_c;

    // Round-robin grant; a drain frees the buffer for a same-cycle accept.
    always_comb begin
        both_c      = bus.req0_valid_in & bus.req1_valid_in;
        grant_vld_c = bus.req0_valid_in | bus.req1_valid_in;
        grant_c     = both_c ? ~last_q : bus.req1_valid_in;
        drain_c     = full_q & (owner_q ? bus.rsp1_ready_in : bus.rsp0_ready_in);
        accept_c    = (~full_q | drain_c) & grant_vld_c;
    end

    always_comb begin
        func_c = grant_c ? bus.req1_func_in : bus.req0_func_in;
        a_c    = grant_c ? bus.req1_a_in    : bus.req0_a_in;
        b_c    = grant_c ? bus.req1_b_in    : bus.req0_b_in;
    end

    // Shared ALU: branch ops pass operand A through as O_out.
    always_comb begin
        alu_o_c  = '0;
        alu_br_c = 1'b0;
        alu_j_c  = 1'b0;
        case (func_c)
            F_ADD, F_ADDU: alu_o_c = a_c + b_c;
            F_SUB, F_SUBU: alu_o_c = a_c - b_c;
            F_AND:         alu_o_c = a_c & b_c;
            F_OR:          alu_o_c = a_c | b_c;
            F_XOR:         alu_o_c = a_c ^ b_c;
            F_NOR:         alu_o_c = ~(a_c | b_c);
            F_SLT:         alu_o_c = WIDTH'($signed(a_c) < $signed(b_c));
            F_SLTU:        alu_o_c = WIDTH'(a_c < b_c);
            F_BEQ: begin
                alu_o_c  = a_c;
                alu_br_c = (a_c == b_c);
            end
            F_BNE: begin
                alu_o_c  = a_c;
                alu_br_c = (a_c != b_c);
            end
            F_J: begin
                alu_o_c = a_c;
                alu_j_c = 1'b1;
            end
            default: alu_o_c = '0;
        endcase
    end

    always_comb begin
        full_d   = full_q;
        owner_d  = owner_q;
        last_d   = last_q;
        result_d = result_q;
        branch_d = branch_q;
        jump_d   = jump_q;
        cnt_d    = cnt_q;
        if (accept_c) begin
            full_d   = 1'b1;
            owner_d  = grant_c;
            last_d   = grant_c;
            result_d = alu_o_c;
            branch_d = alu_br_c;
            jump_d   = alu_j_c;
            if (both_c && !(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (drain_c) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q   <= 1'b0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            result_q <= '0;
            branch_q <= 1'b0;
            jump_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            full_q   <= full_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            result_q <= result_d;
            branch_q <= branch_d;
            jump_q   <= jump_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.req0_ready_out   = accept_c & ~grant_c;
    assign bus.req1_ready_out   = accept_c & grant_c;
    assign bus.rsp0_valid_out   = full_q & ~owner_q;
    assign bus.rsp1_valid_out   = full_q & owner_q;
    assign bus.rsp_result_out   = result_q;
    assign bus.rsp_branch_out   = branch_q;
    assign bus.rsp_jump_out     = jump_q;
    assign bus.conflict_cnt_out = cnt_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter; a second instance with a 4-bit
// conflict counter mirrors the same traffic to exercise saturation.
module tb_alu_share_arbiter;
    logic clk;
    logic reset;

    alu_share_arbiter_if #(.CNT_W(16), .WIDTH(32)) bus ();
    alu_share_arbiter_if #(.CNT_W(4),  .WIDTH(32)) bus_s ();

    alu_share_arbiter #(.CNT_W(16), .WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    alu_share_arbiter #(.CNT_W(4),  .WIDTH(32)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));

    assign bus_s.req0_valid_in = bus.req0_valid_in;
    assign bus_s.req0_func_in  = bus.req0_func_in;
    assign bus_s.req0_a_in     = bus.req0_a_in;
    assign bus_s.req0_b_in     = bus.req0_b_in;
    assign bus_s.req1_valid_in = bus.req1_valid_in;
    assign bus_s.req1_func_in  = bus.req1_func_in;
    assign bus_s.req1_a_in     = bus.req1_a_in;
    assign bus_s.req1_b_in     = bus.req1_b_in;
    assign bus_s.rsp0_ready_in = bus.rsp0_ready_in;
    assign bus_s.rsp1_ready_in = bus.rsp1_ready_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        owner;
        logic [31:0] res;
        logic        br;
        logic        j;
    } rsp_t;

    rsp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic rsp_t golden(input logic owner, input logic [5:0] f,
                                    input logic [31:0] a, input logic [31:0] b);
        rsp_t r;
        r.owner = owner;
        r.res   = 32'd0;
        r.br    = 1'b0;
        r.j     = 1'b0;
        if (f == 6'b100000)      r.res = a + b;
        else if (f == 6'b100010) r.res = a - b;
        else if (f == 6'b100101) r.res = a | b;
        else if (f == 6'b100100) r.res = a & b;
        else if (f == 6'b001100) begin r.res = a; r.br = (a == b); end
        else if (f == 6'b001101) begin r.res = a; r.br = (a != b); end
        else if (f == 6'b001000) begin r.res = a; r.j = 1'b1; end
        return r;
    endfunction

    // Called at a falling edge with inputs already applied; exp_g = -1 means no grant.
    task automatic tick(input int exp_g);
        logic [1:0] exp_rdy;
        logic [1:0] got_rdy;
        logic [35:0] exp_rsp;
        logic [35:0] got_rsp;
        rsp_t e;
        #1;
        exp_rdy = {exp_g == 1, exp_g == 0};
        got_rdy = {bus.req1_ready_out, bus.req0_ready_out};
        n_vec++;
        if (got_rdy !== exp_rdy) begin
            n_err++;
            $display("FAIL ready: got %b required %b at %0t", got_rdy, exp_rdy, $time);
        end
        if (sb.size() > 0) begin
            if ((sb[0].owner == 1'b0 && bus.rsp0_ready_in) ||
                (sb[0].owner == 1'b1 && bus.rsp1_ready_in)) void'(sb.pop_front());
        end
        if (exp_g == 0)
            sb.push_back(golden(1'b0, bus.req0_func_in, bus.req0_a_in, bus.req0_b_in));
        else if (exp_g == 1)
            sb.push_back(golden(1'b1, bus.req1_func_in, bus.req1_a_in, bus.req1_b_in));
        @(posedge clk);
        @(negedge clk);
        got_rsp = {bus.rsp1_valid_out, bus.rsp0_valid_out, bus.rsp_result_out,
                   bus.rsp_branch_out, bus.rsp_jump_out};
        if (sb.size() > 0) begin
            e = sb[0];
            exp_rsp = {e.owner, ~e.owner, e.res, e.br, e.j};
        end else begin
            exp_rsp = {2'b00, got_rsp[33:0]};
        end
        n_vec++;
        if (got_rsp !== exp_rsp) begin
            n_err++;
            $display("FAIL rsp: got %h required %h at %0t", got_rsp, exp_rsp, $time);
        end
    endtask

    task automatic set_req(input int n, input logic v, input logic [5:0] f,
                           input logic [31:0] a, input logic [31:0] b);
        if (n == 0) begin
            bus.req0_valid_in = v; bus.req0_func_in = f; bus.req0_a_in = a; bus.req0_b_in = b;
        end else begin
            bus.req1_valid_in = v; bus.req1_func_in = f; bus.req1_a_in = a; bus.req1_b_in = b;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_req(0, 1'b0, 6'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 6'd0, 32'd0, 32'd0);
        bus.rsp0_ready_in = 1'b0;
        bus.rsp1_ready_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic check_cnt(input string name, input logic [15:0] exp16, input logic [3:0] exp4);
        n_vec++;
        if (bus.conflict_cnt_out !== exp16) begin
            n_err++;
            $display("FAIL %s cnt16: got %0d required %0d", name, bus.conflict_cnt_out, exp16);
        end
        n_vec++;
        if (bus_s.conflict_cnt_out !== exp4) begin
            n_err++;
            $display("FAIL %s cnt4: got %0d required %0d", name, bus_s.conflict_cnt_out, exp4);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({bus.rsp1_valid_out, bus.rsp0_valid_out} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_valid: got %b required 00", {bus.rsp1_valid_out, bus.rsp0_valid_out});
        end
        set_req(0, 1'b1, 6'b100000, 32'd1, 32'd2);
        set_req(1, 1'b1, 6'b100000, 32'd3, 32'd4);
        tick(0);
        check_cnt("pre_reset", 16'd1, 4'd1);
        reset = 1'b1;
        #1;
        n_vec++;
        if ({bus.rsp1_valid_out, bus.rsp0_valid_out} !== 2'b00) begin
            n_err++;
            $display("FAIL midreset_valid: got %b required 00", {bus.rsp1_valid_out, bus.rsp0_valid_out});
        end
        check_cnt("midreset", 16'd0, 4'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        bus.rsp0_ready_in = 1'b1;
        bus.rsp1_ready_in = 1'b1;
        tick(0);
        set_req(0, 1'b0, 6'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 6'd0, 32'd0, 32'd0);
        tick(-1);
    endtask

    task automatic test_single_add();
        do_reset();
        bus.rsp0_ready_in = 1'b1;
        set_req(0, 1'b1, 6'b100000, 32'd5, 32'd7);
        tick(0);
        n_vec++;
        if (bus.rsp_result_out !== 32'd12) begin
            n_err++;
            $display("FAIL add_result: got %0d required 12", bus.rsp_result_out);
        end
        set_req(0, 1'b0, 6'd0, 32'd0, 32'd0);
        tick(-1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.rsp0_ready_in = 1'b1;
        bus.rsp1_ready_in = 1'b1;
        set_req(0, 1'b1, 6'b100010, 32'd3, 32'd5);
        set_req(1, 1'b1, 6'b100101, 32'hF0, 32'h0F);
        for (int i = 0; i < 4; i++) tick(i % 2);
        set_req(0, 1'b0, 6'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 6'd0, 32'd0, 32'd0);
        tick(-1);
        check_cnt("b2b", 16'd4, 4'd4);
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.rsp0_ready_in = 1'b0;
        bus.rsp1_ready_in = 1'b1;
        set_req(0, 1'b1, 6'b100000, 32'd100, 32'd23);
        tick(0);
        set_req(0, 1'b0, 6'd0, 32'd0, 32'd0);
        set_req(1, 1'b1, 6'b100100, 32'hFF00, 32'h0FF0);
        for (int i = 0; i < 3; i++) tick(-1);
        bus.rsp0_ready_in = 1'b1;
        tick(1);
        set_req(1, 1'b0, 6'd0, 32'd0, 32'd0);
        tick(-1);
        check_cnt("bp", 16'd0, 4'd0);
    endtask

    task automatic test_branch_jump();
        do_reset();
        bus.rsp1_ready_in = 1'b1;
        set_req(1, 1'b1, 6'b001100, 32'd3, 32'd3);
        tick(1);
        n_vec++;
        if ({bus.rsp_branch_out, bus.rsp_result_out} !== {1'b1, 32'd3}) begin
            n_err++;
            $display("FAIL beq: got br=%b res=%0d required br=1 res=3", bus.rsp_branch_out, bus.rsp_result_out);
        end
        set_req(1, 1'b1, 6'b001101, 32'd3, 32'd3);
        tick(1);
        n_vec++;
        if (bus.rsp_branch_out !== 1'b0) begin
            n_err++;
            $display("FAIL bne: got br=%b required 0", bus.rsp_branch_out);
        end
        set_req(1, 1'b1, 6'b001000, 32'h40, 32'd0);
        tick(1);
        n_vec++;
        if (bus.rsp_jump_out !== 1'b1) begin
            n_err++;
            $display("FAIL jump: got %b required 1", bus.rsp_jump_out);
        end
        set_req(1, 1'b0, 6'd0, 32'd0, 32'd0);
        tick(-1);
    endtask

    task automatic test_saturation();
        do_reset();
        bus.rsp0_ready_in = 1'b1;
        bus.rsp1_ready_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_req(0, 1'b1, 6'b100000, 32'(i), 32'd1);
            set_req(1, 1'b1, 6'b100010, 32'(i), 32'd1);
            tick(i % 2);
            check_cnt("sat", 16'(i + 1), (i + 1 > 15) ? 4'd15 : 4'(i + 1));
        end
        set_req(0, 1'b0, 6'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 6'd0, 32'd0, 32'd0);
        tick(-1);
        check_cnt("sat_hold", 16'd20, 4'd15);
    endtask

    initial begin
        reset = 1'b1;
        bus.rsp0_ready_in = 1'b0;
        bus.rsp1_ready_in = 1'b0;
        set_req(0, 1'b0, 6'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 6'd0, 32'd0, 32'd0);
        @(negedge clk);
        test_reset();
        test_single_add();
        test_back_to_back();
        test_backpressure();
        test_branch_jump();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
